qpsk_mod_param: RTL and testbench

Parametrised QPSK modulator producing a continuous stream of signed carrier samples from a handshaked stream of 2-bit symbols (I bit, Q bit). Generalises the fixed 8-bit, four-case modulator to configurable sample width and samples-per-symbol, with flow control, seamless back-to-back symbols, underrun handling, and an optional differential (DQPSK) mode. Sits between the symbol source (framer/scrambler) and the DAC interface.

---
 rtl/qpsk_mod_param.sv | 121 ++++++++++++
 tb/tb_qpsk_mod_param.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_mod_param.sv
// qpsk_mod_param: QPSK carrier modulator; one carrier cycle of SPS signed
// samples per accepted 2-bit symbol, with valid/ready symbol input.
// Ports: clk, rst_n (async low); sym_valid/sym_i/sym_q/sym_ready symbol
// stream; out/out_valid sample stream; underrun pulse on starvation.
// Define QPSK_DIFF_EN for differential (DQPSK) phase encoding.
// LUT_FILE names the matching hex table image; the same sine table is
// generated here at elaboration so no external file is needed.
module qpsk_mod_param #(
  parameter int DATA_W   = 8,
  parameter int SPS      = 16,
  parameter     LUT_FILE = "qpsk_sin.hex"
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sym_valid,
  input  logic                     sym_i,
  input  logic                     sym_q,
  output logic                     sym_ready,
  output logic signed [DATA_W:0]   out,
  output logic                     out_valid,
  output logic                     underrun
);

  localparam int  CW = $clog2(SPS);
  localparam real PI = 3.14159265358979;

  // round((2^(DATA_W-1)-1) * sin(2*pi*k/SPS)), packed entry k at k*DATA_W
  function automatic logic [SPS*DATA_W-1:0] sin_table();
    logic [SPS*DATA_W-1:0] t;
    real x, term, acc, amp, y;
    int  v;
    t   = '0;
    amp = real'((1 << (DATA_W - 1)) - 1);
    for (int k = 0; k < SPS; k++) begin
      x = 2.0 * PI * real'(k) / real'(SPS);
      if (x > PI) x = x - 2.0 * PI;
      term = x;
      acc  = x;
      for (int n = 1; n < 12; n++) begin
        term = -term * x * x / real'((2 * n) * (2 * n + 1));
        acc  = acc + term;
      end
      y = amp * acc;
      if (y >= 0.0) v = $rtoi(y + 0.5);
      else          v = $rtoi(y - 0.5);
      t[k*DATA_W +: DATA_W] = v[DATA_W-1:0];
    end
    return t;
  endfunction

  localparam logic [SPS*DATA_W-1:0] LUT = sin_table();

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      quad;
  logic            starve;

  logic            accept;
  logic [1:0]      nquad;
  logic [CW-1:0]   cidx;
  logic signed [DATA_W-1:0] sin_v;
  logic signed [DATA_W-1:0] cos_v;
  logic signed [DATA_W:0]   s_x;
  logic signed [DATA_W:0]   c_x;
  logic signed [DATA_W:0]   samp;

  assign sym_ready = (state == IDLE) ||
                     (state == RUN && cnt == CW'(SPS - 1));
  assign accept    = sym_valid && sym_ready;

`ifdef QPSK_DIFF_EN
  // quad doubles as the phase register p; dibit is a phase step
  assign nquad = quad + {sym_i, sym_i ^ sym_q};
`else
  assign nquad = {sym_q, sym_i ^ sym_q};
`endif

  // cos_k is the sine table a quarter cycle ahead; wraps since SPS is 2^n
  assign cidx  = cnt + CW'(SPS / 4);
  assign sin_v = LUT[int'(cnt) * DATA_W +: DATA_W];
  assign cos_v = LUT[int'(cidx) * DATA_W +: DATA_W];
  assign s_x   = {sin_v[DATA_W-1], sin_v};
  assign c_x   = {cos_v[DATA_W-1], cos_v};

  // I negative in p1/p2, Q negative in p2/p3
  assign samp  = ((quad[1] ^ quad[0]) ? -c_x : c_x) +
                 (quad[1] ? -s_x : s_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      quad      <= '0;
      starve    <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      // out is built from the current cnt/quad, so sample k of a symbol
      // lands one edge after cnt==k
      out_valid <= (state == RUN);
      out       <= (state == RUN) ? samp : '0;
      underrun  <= starve;
      starve    <= 1'b0;
      if (accept) begin
        state <= RUN;
        cnt   <= '0;
        quad  <= nquad;
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
        if (cnt == CW'(SPS - 1)) begin
          state  <= IDLE;
          starve <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qpsk_mod_param.sv
// tb_qpsk_mod_param: directed bench for qpsk_mod_param, DATA_W=8, SPS=16.
// Expected samples come from a hand-computed sine table.
module tb_qpsk_mod_param;

  localparam int DW = 8;
  localparam int SPS = 16;
  localparam int OW = DW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sym_valid = 1'b0;
  logic sym_i = 1'b0;
  logic sym_q = 1'b0;
  logic sym_ready;
  logic signed [DW:0] out;
  logic out_valid;
  logic underrun;

  int checks = 0;
  int failures = 0;
  int mp = 0;

  // round(127*sin(2*pi*k/16))
  int tbl [16] = '{0, 49, 90, 117, 127, 117, 90, 49,
                   0, -49, -90, -117, -127, -117, -90, -49};

  qpsk_mod_param #(.DATA_W(DW), .SPS(SPS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sym_valid(sym_valid),
    .sym_i(sym_i),
    .sym_q(sym_q),
    .sym_ready(sym_ready),
    .out(out),
    .out_valid(out_valid),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_quad(logic i, logic q);
    int r;
`ifdef QPSK_DIFF_EN
    case ({i, q})
      2'b00:   r = 0;
      2'b01:   r = 1;
      2'b11:   r = 2;
      default: r = 3;
    endcase
    mp = (mp + r) % 4;
    r = mp;
`else
    case ({i, q})
      2'b00:   r = 0;
      2'b10:   r = 1;
      2'b11:   r = 2;
      default: r = 3;
    endcase
`endif
    return r;
  endfunction

  function automatic int exp_samp(int k, int qd);
    int c, s;
    c = tbl[(k + 4) % 16];
    s = tbl[k];
    if (qd == 1 || qd == 2) c = -c;
    if (qd >= 2) s = -s;
    return c + s;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (out !== '0 || out_valid !== 1'b0 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold out=%0d v=%b u=%b want 0/0/0",
               out, out_valid, underrun);
    end
    rst_n = 1'b1;
    mp = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (out !== '0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_out c=%0d out=%0d v=%b want 0/0",
                 c, out, out_valid);
      end
      checks++;
      if (underrun !== 1'b0) begin
        failures++;
        $display("FAIL idle_underrun c=%0d got %b want 0", c, underrun);
      end
      checks++;
      if (sym_ready !== 1'b1) begin
        failures++;
        $display("FAIL idle_ready c=%0d got %b want 1", c, sym_ready);
      end
    end
  endtask

  task automatic test_single();
    int qd;
    int want [4] = '{127, 127, -127, -127};
    sym_valid = 1'b1;
    {sym_i, sym_q} = 2'b00;
    qd = model_quad(1'b0, 1'b0);
    tick();
    sym_valid = 1'b0;
    checks++;
    if (sym_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_ready0 got %b want 0", sym_ready);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || underrun !== 1'b0) begin
        failures++;
        $display("FAIL single_valid k=%0d v=%b u=%b want 1/0",
                 k, out_valid, underrun);
      end
      checks++;
      if (out !== OW'(exp_samp(k, qd))) begin
        failures++;
        $display("FAIL single_samp k=%0d got %0d want %0d",
                 k, out, exp_samp(k, qd));
      end
      if (k % 4 == 0) begin
        checks++;
        if (out !== OW'(want[k / 4])) begin
          failures++;
          $display("FAIL single_spot k=%0d got %0d want %0d",
                   k, out, want[k / 4]);
        end
      end
    end
    tick();
    checks++;
    if (out !== '0 || out_valid !== 1'b0 || underrun !== 1'b1) begin
      failures++;
      $display("FAIL single_underrun out=%0d v=%b u=%b want 0/0/1",
               out, out_valid, underrun);
    end
    checks++;
    if (sym_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready_idle got %b want 1", sym_ready);
    end
    // accept a new symbol in the underrun cycle itself
    sym_valid = 1'b1;
    {sym_i, sym_q} = 2'b01;
    qd = model_quad(1'b0, 1'b1);
    tick();
    sym_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL restart_gap v=%b u=%b want 0/0", out_valid, underrun);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out !== OW'(exp_samp(k, qd))) begin
        failures++;
        $display("FAIL restart_samp k=%0d v=%b got %0d want %0d",
                 k, out_valid, out, exp_samp(k, qd));
      end
    end
    tick();
    checks++;
    if (underrun !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL restart_underrun u=%b v=%b want 1/0",
               underrun, out_valid);
    end
    tick();
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_pulse got %b want 0", underrun);
    end
  endtask

  task automatic test_stream();
    logic [1:0] d [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int want0 [4] = '{127, -127, -127, 127};
    int qa [4];
    int k, s;
    sym_valid = 1'b1;
    {sym_i, sym_q} = d[0];
    qa[0] = model_quad(d[0][1], d[0][0]);
    tick();
    for (int e = 0; e <= 65; e++) begin
      if (e >= 1 && e <= 64) begin
        k = (e - 1) % 16;
        s = (e - 1) / 16;
        checks++;
        if (out_valid !== 1'b1 || underrun !== 1'b0) begin
          failures++;
          $display("FAIL stream_valid e=%0d v=%b u=%b want 1/0",
                   e, out_valid, underrun);
        end
        checks++;
        if (out !== OW'(exp_samp(k, qa[s]))) begin
          failures++;
          $display("FAIL stream_samp e=%0d got %0d want %0d",
                   e, out, exp_samp(k, qa[s]));
        end
`ifndef QPSK_DIFF_EN
        if (k == 0) begin
          checks++;
          if (out !== OW'(want0[s])) begin
            failures++;
            $display("FAIL stream_sign s=%0d got %0d want %0d",
                     s, out, want0[s]);
          end
        end
`endif
      end
      if (e <= 63) begin
        checks++;
        if (sym_ready !== (e % 16 == 15)) begin
          failures++;
          $display("FAIL stream_ready e=%0d got %b want %b",
                   e, sym_ready, (e % 16 == 15));
        end
      end
      if (e == 65) begin
        checks++;
        if (out_valid !== 1'b0 || underrun !== 1'b1) begin
          failures++;
          $display("FAIL stream_end v=%b u=%b want 0/1",
                   out_valid, underrun);
        end
      end
      if (e % 16 == 0 && e < 48) begin
        {sym_i, sym_q} = d[e / 16 + 1];
        qa[e / 16 + 1] = model_quad(sym_i, sym_q);
      end
      if (e == 48) sym_valid = 1'b0;
      if (e < 65) tick();
    end
  endtask

  task automatic test_backpressure();
    int qa, qb, qd;
    sym_valid = 1'b1;
    {sym_i, sym_q} = 2'b11;
    qa = model_quad(1'b1, 1'b1);
    qb = 0;
    tick();
    sym_valid = 1'b0;
    for (int e = 0; e <= 33; e++) begin
      if (e <= 16) begin
        checks++;
        if (sym_ready !== (e == 15)) begin
          failures++;
          $display("FAIL bp_ready e=%0d got %b want %b",
                   e, sym_ready, (e == 15));
        end
      end
      if (e >= 1 && e <= 32) begin
        qd = (e <= 16) ? qa : qb;
        checks++;
        if (out_valid !== 1'b1 ||
            out !== OW'(exp_samp((e - 1) % 16, qd))) begin
          failures++;
          $display("FAIL bp_samp e=%0d v=%b got %0d want %0d",
                   e, out_valid, out, exp_samp((e - 1) % 16, qd));
        end
      end
      if (e == 33) begin
        checks++;
        if (out_valid !== 1'b0 || underrun !== 1'b1) begin
          failures++;
          $display("FAIL bp_end v=%b u=%b want 0/1", out_valid, underrun);
        end
      end
      if (e == 5) begin
        sym_valid = 1'b1;
        {sym_i, sym_q} = 2'b10;
        qb = model_quad(1'b1, 1'b0);
      end
      if (e == 16) sym_valid = 1'b0;
      if (e < 33) tick();
    end
  endtask

  task automatic test_async_reset();
    int qd;
    sym_valid = 1'b1;
    {sym_i, sym_q} = 2'b10;
    qd = model_quad(1'b1, 1'b0);
    tick();
    sym_valid = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out !== OW'(exp_samp(e - 1, qd))) begin
        failures++;
        $display("FAIL ar_pre e=%0d v=%b got %0d want %0d",
                 e, out_valid, out, exp_samp(e - 1, qd));
      end
    end
    // cnt is 7 here; reset lands between clock edges
    rst_n = 1'b0;
    mp = 0;
    #1;
    checks++;
    if (out !== '0 || out_valid !== 1'b0 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL ar_clear out=%0d v=%b u=%b want 0/0/0",
               out, out_valid, underrun);
    end
    checks++;
    if (sym_ready !== 1'b1) begin
      failures++;
      $display("FAIL ar_ready got %b want 1", sym_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sym_valid = 1'b1;
    {sym_i, sym_q} = 2'b00;
    qd = model_quad(1'b0, 1'b0);
    tick();
    sym_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out !== OW'(exp_samp(k, qd))) begin
        failures++;
        $display("FAIL ar_samp k=%0d v=%b got %0d want %0d",
                 k, out_valid, out, exp_samp(k, qd));
      end
      if (k == 0) begin
        checks++;
        if (out !== OW'(127)) begin
          failures++;
          $display("FAIL ar_first got %0d want 127", out);
        end
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || underrun !== 1'b1) begin
      failures++;
      $display("FAIL ar_end v=%b u=%b want 0/1", out_valid, underrun);
    end
    tick();
  endtask

`ifdef QPSK_DIFF_EN
  task automatic test_diff();
    logic [1:0] d [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    int hq [5] = '{1, 2, 3, 0, 0};
    int want0 [5] = '{-127, -127, 127, 127, 127};
    int k, s;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mp = 0;
    tick();
    sym_valid = 1'b1;
    {sym_i, sym_q} = d[0];
    tick();
    for (int e = 0; e <= 81; e++) begin
      if (e >= 1 && e <= 80) begin
        k = (e - 1) % 16;
        s = (e - 1) / 16;
        checks++;
        if (out_valid !== 1'b1 || out !== OW'(exp_samp(k, hq[s]))) begin
          failures++;
          $display("FAIL diff_samp e=%0d v=%b got %0d want %0d",
                   e, out_valid, out, exp_samp(k, hq[s]));
        end
        if (k == 0) begin
          checks++;
          if (out !== OW'(want0[s])) begin
            failures++;
            $display("FAIL diff_sign s=%0d got %0d want %0d",
                     s, out, want0[s]);
          end
        end
      end
      if (e == 81) begin
        checks++;
        if (out_valid !== 1'b0 || underrun !== 1'b1) begin
          failures++;
          $display("FAIL diff_end v=%b u=%b want 0/1", out_valid, underrun);
        end
      end
      if (e % 16 == 0 && e < 64) {sym_i, sym_q} = d[e / 16 + 1];
      if (e == 64) sym_valid = 1'b0;
      if (e < 81) tick();
    end
    mp = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_async_reset();
`ifdef QPSK_DIFF_EN
    test_diff();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
